// File: rtl/alarm_pkg.sv
// Shared types and defaults for the alarm ring controller slice.
package alarm_pkg;

  // Controller modes; encoding is visible on debug taps so keep it fixed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_t;

  localparam int RING_SEC_DEF   = 60;
  localparam int SNOOZE_SEC_DEF = 300;
  localparam int SNOOZE_MAX_DEF = 3;
  localparam int TONE_DIV_DEF   = 25_000;

  // hh:mm as four BCD digits, used to compare live time against alarm time.
  typedef struct packed {
    logic [3:0] hour_h;
    logic [3:0] hour_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
  } hhmm_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Signal bundle between the clock/alarm counter side and the ring controller.
interface alarm_ring_ctrl_if #(
  parameter int SNOOZE_MAX = 3
);
  localparam int SNOOZE_W = $clog2(SNOOZE_MAX + 1);

  logic                tick_1s;
  logic                alarm_en;
  logic [1:0]          adjust;
  logic                key_stop;
  logic                key_snooze;
  logic [3:0]          hour_h;
  logic [3:0]          hour_l;
  logic [3:0]          min_h;
  logic [3:0]          min_l;
  logic [3:0]          sec_h;
  logic [3:0]          sec_l;
  logic [3:0]          alarm_hour_h;
  logic [3:0]          alarm_hour_l;
  logic [3:0]          alarm_min_h;
  logic [3:0]          alarm_min_l;
  logic                buzzer;
  logic                ringing;
  logic                snoozing;
  logic [SNOOZE_W-1:0] snooze_cnt;
  logic                missed;

  modport master (
    output tick_1s, alarm_en, adjust, key_stop, key_snooze,
    output hour_h, hour_l, min_h, min_l, sec_h, sec_l,
    output alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l,
    input  buzzer, ringing, snoozing, snooze_cnt, missed
  );

  modport slave (
    input  tick_1s, alarm_en, adjust, key_stop, key_snooze,
    input  hour_h, hour_l, min_h, min_l, sec_h, sec_l,
    input  alarm_hour_h, alarm_hour_l, alarm_min_h, alarm_min_l,
    output buzzer, ringing, snoozing, snooze_cnt, missed
  );

endinterface

// File: rtl/alarm_ring_ctrl_tone_gen.sv
// Square-wave buzzer generator, active only while the controller rings.
// Build option ALARM_BEEP_PATTERN_EN adds a 1 s on / 1 s off beep gate.
import alarm_pkg::*;

module tone_gen #(
  parameter int TONE_DIV = TONE_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ring,
  input  logic tick_1s,
  output logic buzzer
);

  localparam int CNT_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TONE_DIV - 1);

  logic [CNT_W-1:0] tone_cnt;
  logic             tone;

  // Half-period divider; held at zero outside RING so every ring starts silent-low.
  always_ff @(posedge clk) begin
    if (rst || !ring) begin
      tone_cnt <= '0;
      tone     <= 1'b0;
    end else if (tone_cnt == CNT_LAST) begin
      tone_cnt <= '0;
      tone     <= ~tone;
    end else begin
      tone_cnt <= tone_cnt + 1'b1;
    end
  end

`ifdef ALARM_BEEP_PATTERN_EN
  logic beep_phase;

  // Beep gate sits at 1 while not ringing so RING always opens with an audible second.
  always_ff @(posedge clk) begin
    if (rst) begin
      beep_phase <= 1'b0;
    end else if (!ring) begin
      beep_phase <= 1'b1;
    end else if (tick_1s) begin
      beep_phase <= ~beep_phase;
    end
  end

  assign buzzer = tone && ring && beep_phase;
`else
  logic unused_tick;
  assign unused_tick = tick_1s;
  assign buzzer      = tone && ring;
`endif

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: detects the alarm minute, runs ring timeout and
// snooze re-arm, and drives the buzzer through tone_gen.
// Build option ALARM_BEEP_PATTERN_EN selects a pulsed beep instead of a steady tone.
import alarm_pkg::*;

module alarm_ring_ctrl #(
  parameter int RING_SEC   = RING_SEC_DEF,
  parameter int SNOOZE_SEC = SNOOZE_SEC_DEF,
  parameter int SNOOZE_MAX = SNOOZE_MAX_DEF,
  parameter int TONE_DIV   = TONE_DIV_DEF
) (
  input logic             clk,
  input logic             rst,
  alarm_ring_ctrl_if.slave bus
);

  localparam int SEC_W = $clog2(max_int(RING_SEC, SNOOZE_SEC));
  localparam int SNZ_W = $clog2(SNOOZE_MAX + 1);
  localparam logic [SEC_W-1:0] RING_LAST   = SEC_W'(RING_SEC - 1);
  localparam logic [SEC_W-1:0] SNOOZE_LAST = SEC_W'(SNOOZE_SEC - 1);
  localparam logic [SNZ_W-1:0] SNZ_LIMIT   = SNZ_W'(SNOOZE_MAX);

  state_t           state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [SNZ_W-1:0] snz_q, snz_d;
  logic             missed_q, missed_d;
  logic             match, match_d, match_dd, trig;
  hhmm_t            live_hm, alarm_hm;
  logic             buzzer_w;

  assign live_hm  = {bus.hour_h, bus.hour_l, bus.min_h, bus.min_l};
  assign alarm_hm = {bus.alarm_hour_h, bus.alarm_hour_l, bus.alarm_min_h, bus.alarm_min_l};

  assign match = bus.alarm_en && (bus.adjust == 2'd0) && (live_hm == alarm_hm) &&
                 (bus.sec_h == 4'd0) && (bus.sec_l == 4'd0);

  // The edge is taken on the registered match so the state register sees a
  // clean, glitch-free trigger two clocks after the seconds roll to 00.
  assign trig = match_d && !match_dd;

  // Match pipeline feeding the rising-edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_d  <= 1'b0;
      match_dd <= 1'b0;
    end else begin
      match_d  <= match;
      match_dd <= match_d;
    end
  end

  // Controller state, second counter, snooze count and missed flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sec_q    <= '0;
      snz_q    <= '0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      snz_q    <= snz_d;
      missed_q <= missed_d;
    end
  end

  // Next-state logic: disarm beats stop, stop beats timeout, timeout beats snooze.
  always_comb begin
    state_d  = state_q;
    sec_d    = sec_q;
    snz_d    = snz_q;
    missed_d = missed_q;
    if (!bus.alarm_en) begin
      state_d = IDLE;
      sec_d   = '0;
      snz_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig) begin
            state_d  = RING;
            sec_d    = '0;
            snz_d    = '0;
            missed_d = 1'b0;
          end else if (bus.key_stop) begin
            missed_d = 1'b0;
          end
        end
        RING: begin
          if (bus.key_stop) begin
            state_d = IDLE;
          end else if (bus.tick_1s && (sec_q == RING_LAST)) begin
            state_d  = IDLE;
            missed_d = 1'b1;
          end else if (bus.key_snooze && (snz_q < SNZ_LIMIT)) begin
            state_d = SNOOZE;
            snz_d   = snz_q + 1'b1;
            sec_d   = '0;
          end else if (bus.tick_1s) begin
            sec_d = sec_q + 1'b1;
          end
        end
        SNOOZE: begin
          if (bus.key_stop) begin
            state_d = IDLE;
          end else if (bus.tick_1s && (sec_q == SNOOZE_LAST)) begin
            state_d = RING;
            sec_d   = '0;
          end else if (bus.tick_1s) begin
            sec_d = sec_q + 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  tone_gen #(
    .TONE_DIV(TONE_DIV)
  ) u_tone (
    .clk    (clk),
    .rst    (rst),
    .ring   (state_q == RING),
    .tick_1s(bus.tick_1s),
    .buzzer (buzzer_w)
  );

  assign bus.buzzer     = buzzer_w;
  assign bus.ringing    = (state_q == RING);
  assign bus.snoozing   = (state_q == SNOOZE);
  assign bus.snooze_cnt = snz_q;
  assign bus.missed     = missed_q;

endmodule
